// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline sequencer: valid bits, IR loads, RAW stall, branch flush, halt
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       ir3,
  input  logic [7:0]       ir4,
  input  logic [7:0]       ir5,
  input  logic             br_taken,
  output logic             PCWrite,
  output logic             PCSel,
  output logic             IR1Load,
  output logic             IR2Load,
  output logic             IR3Load,
  output logic             IR4Load,
  output logic             IR5Load,
  output logic [4:0]       valid,
  output logic             RFWrite,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_t;

  state_t state;

  // Instruction writes a register (LOAD, ADD, SUB, NAND, ORI, SHIFT).
  function automatic logic writes_reg(input logic [7:0] ir);
    logic w;
    casez (ir[3:0])
      4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b?111, 4'b?011: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // Destination register; ORI always targets R1.
  function automatic logic [1:0] dest_reg(input logic [7:0] ir);
    return (ir[2:0] == 3'b111) ? 2'd1 : ir[7:6];
  endfunction

  // One-hot set of registers read by the instruction.
  function automatic logic [3:0] read_mask(input logic [7:0] ir);
    logic [3:0] m;
    casez (ir[3:0])
      4'b0000:                   m = 4'b0001 << ir[5:4];
      4'b0010, 4'b0100,
      4'b0110, 4'b1000:          m = (4'b0001 << ir[7:6]) | (4'b0001 << ir[5:4]);
      4'b?111:                   m = 4'b0010;
      4'b?011:                   m = 4'b0001 << ir[7:6];
      default:                   m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_branch(input logic [7:0] ir);
    return (ir[3:0] == 4'b0101) || (ir[3:0] == 4'b1001) || (ir[3:0] == 4'b1101);
  endfunction

  logic [3:0] rf_reads;
  logic       haz_ex;
  logic       haz_wb;
  logic       act_stop;
  logic       act_flush;
  logic       act_stall;
  logic       do_flush;
  logic       do_stall;
  logic       unused_ir_bits;

  // Only opcode and Rx matter for the EX/WB writers.
  assign unused_ir_bits = ^{ir4[5:4], ir5[5:4]};

  // Decode this cycle's action; STOP beats FLUSH beats STALL, otherwise ADVANCE.
  always_comb begin
    rf_reads  = read_mask(ir3);
    haz_ex    = valid[3] & writes_reg(ir4) & rf_reads[dest_reg(ir4)];
    haz_wb    = valid[4] & writes_reg(ir5) & rf_reads[dest_reg(ir5)];
    act_stop  = valid[3] & (ir4[3:0] == 4'b0001);
    act_flush = valid[3] & is_branch(ir4) & br_taken;
    act_stall = valid[2] & (haz_ex | haz_wb);
    do_flush  = act_flush & ~act_stop;
    do_stall  = act_stall & ~act_stop & ~act_flush;
  end

  // Enables derived from the registered state and the current action.
  always_comb begin
    PCWrite = 1'b0;
    PCSel   = 1'b0;
    IR1Load = 1'b0;
    IR2Load = 1'b0;
    IR3Load = 1'b0;
    IR4Load = 1'b0;
    IR5Load = 1'b0;
    RFWrite = 1'b0;
    halted  = (state == S_HALT);
    if (state == S_RUN) begin
      RFWrite = valid[4] & writes_reg(ir5);
      IR4Load = 1'b1;
      IR5Load = 1'b1;
      if (!do_stall) begin
        PCWrite = 1'b1;
        PCSel   = ~do_flush;
        IR1Load = 1'b1;
        IR2Load = 1'b1;
        IR3Load = 1'b1;
      end
    end
  end

  // State, valid bits and the saturating stall/flush counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      valid     <= 5'b00000;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_INIT: state <= S_RUN;
        S_RUN: begin
          if (do_flush)
            valid <= {valid[3], 3'b000, 1'b1};
          else if (do_stall)
            valid <= {valid[3], 1'b0, valid[2:0]};
          else
            valid <= {valid[3:0], 1'b1};
          if ((do_flush || do_stall) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
          if (act_stop)
            state <= S_HALT;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized and directed checks of pipeline_hazard_ctrl against a pipeline model
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] NOP  = 8'h0A;
  localparam logic [7:0] ADD  = 8'h64;  // ADD R1,R2
  localparam logic [7:0] SUB  = 8'hD6;  // SUB R3,R1
  localparam logic [7:0] BZ   = 8'h05;
  localparam logic [7:0] STOP = 8'h01;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] q1, q2, q3, q4, q5;
  logic bt;

  logic pcw, pcsel, l1, l2, l3, l4, l5, rfw, halted;
  logic [4:0] valid;
  logic [15:0] cnt;
  logic s_pcw, s_pcsel, s_l1, s_l2, s_l3, s_l4, s_l5, s_rfw, s_halted;
  logic [4:0] s_valid;
  logic [1:0] s_cnt;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .ir3(q3), .ir4(q4), .ir5(q5), .br_taken(bt),
    .PCWrite(pcw), .PCSel(pcsel), .IR1Load(l1), .IR2Load(l2), .IR3Load(l3),
    .IR4Load(l4), .IR5Load(l5), .valid(valid), .RFWrite(rfw), .halted(halted),
    .stall_cnt(cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .ir3(q3), .ir4(q4), .ir5(q5), .br_taken(bt),
    .PCWrite(s_pcw), .PCSel(s_pcsel), .IR1Load(s_l1), .IR2Load(s_l2), .IR3Load(s_l3),
    .IR4Load(s_l4), .IR5Load(s_l5), .valid(s_valid), .RFWrite(s_rfw), .halted(s_halted),
    .stall_cnt(s_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  int pc, tgt;
  int m_state;  // 0 INIT, 1 RUN, 2 HALT
  logic [4:0] m_valid;
  int m_cnt;

  function automatic int dest_of(input logic [7:0] ir);
    case (ir[3:0])
      4'd0, 4'd4, 4'd6, 4'd8, 4'd3, 4'd11: return int'(ir[7:6]);
      4'd7, 4'd15: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] srcs_of(input logic [7:0] ir);
    logic [3:0] m = 4'b0000;
    case (ir[3:0])
      4'd0: m[ir[5:4]] = 1'b1;
      4'd2, 4'd4, 4'd6, 4'd8: begin m[ir[7:6]] = 1'b1; m[ir[5:4]] = 1'b1; end
      4'd7, 4'd15: m[1] = 1'b1;
      4'd3, 4'd11: m[ir[7:6]] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_br(input logic [7:0] ir);
    return ir[3:0] == 4'd5 || ir[3:0] == 4'd9 || ir[3:0] == 4'd13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = NOP;
  endtask

  // Assert reset between edges; every output must drop at once.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_pcwrite", pcw, 0);
    chk("rst_pcsel", pcsel, 0);
    chk("rst_loads", {l5, l4, l3, l2, l1}, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rfwrite", rfw, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_cnt_small", s_cnt, 0);
    m_state = 0; m_valid = 5'b0; m_cnt = 0; pc = 0;
    q1 = NOP; q2 = NOP; q3 = NOP; q4 = NOP; q5 = NOP;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance model and instruction pipeline after the edge.
  task automatic cycle();
    int act, d4, d5;
    logic [3:0] s3;
    logic hz, e_pcw, e_sel, e_rfw;
    logic [4:0] e_load;
    @(negedge clock);
    d4 = dest_of(q4);
    d5 = dest_of(q5);
    s3 = srcs_of(q3);
    hz = m_valid[2] && ((m_valid[3] && d4 >= 0 && s3[d4[1:0]]) ||
                        (m_valid[4] && d5 >= 0 && s3[d5[1:0]]));
    act = 0;
    if (m_state == 1) begin
      if (m_valid[3] && q4[3:0] == 4'd1)      act = 4;
      else if (m_valid[3] && is_br(q4) && bt) act = 3;
      else if (hz)                            act = 2;
      else                                    act = 1;
    end
    e_pcw  = (act == 1 || act == 3 || act == 4);
    e_sel  = (act == 1 || act == 4);
    e_load = e_pcw ? 5'b11111 : (act == 2 ? 5'b11000 : 5'b00000);
    e_rfw  = (m_state == 1) && m_valid[4] && (d5 >= 0);
    chk("pcwrite", pcw, e_pcw);
    chk("pcsel", pcsel, e_sel);
    chk("loads", {l5, l4, l3, l2, l1}, e_load);
    chk("valid", valid, m_valid);
    chk("rfwrite", rfw, e_rfw);
    chk("halted", halted, m_state == 2);
    chk("stall_cnt", cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("stall_cnt_small", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
    chk("loads_small", {s_l5, s_l4, s_l3, s_l2, s_l1}, e_load);
    @(posedge clock);
    #1;
    case (act)
      1, 4: begin
        m_valid = {m_valid[3:0], 1'b1};
        q5 = q4; q4 = q3; q3 = q2; q2 = q1; q1 = mem[pc % 64]; pc++;
      end
      2: begin
        m_valid = {m_valid[3], 1'b0, m_valid[2:0]};
        m_cnt++;
        q5 = q4; q4 = NOP;
      end
      3: begin
        m_valid = {m_valid[3], 3'b000, 1'b1};
        m_cnt++;
        q5 = q4; q4 = q3; q3 = q2; q2 = q1; q1 = mem[tgt % 64]; pc = tgt + 1;
      end
      default: ;
    endcase
    if (m_state == 0) m_state = 1;
    else if (act == 4) m_state = 2;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [7:0] r;
    bt = 1'b0; tgt = 20;
    q1 = NOP; q2 = NOP; q3 = NOP; q4 = NOP; q5 = NOP;
    clear_mem();

    // Fill: INIT then five advances.
    do_reset();
    cycles(6);
    chk("fill_valid", valid, 5'b11111);

    // RAW hazard: two stall cycles then advance.
    mem[0] = ADD; mem[1] = SUB;
    do_reset();
    cycles(12);
    chk("raw_stall_cnt", cnt, 2);
    chk("raw_valid", valid, 5'b11111);

    // Reset asserted while stalled.
    do_reset();
    cycles(6);
    do_reset();

    // Taken branch flush; br_taken with non-branches does nothing.
    clear_mem();
    mem[0] = BZ; bt = 1'b1; tgt = 20;
    do_reset();
    cycles(6);
    chk("flush_valid", valid, 5'b10001);
    chk("flush_cnt", cnt, 1);
    cycles(8);
    chk("nobranch_cnt", cnt, 1);

    // Flush beats a coincident RAW stall.
    clear_mem();
    mem[0] = ADD; mem[1] = BZ; mem[2] = SUB;
    do_reset();
    cycles(7);
    chk("flushwin_cnt", cnt, 1);
    chk("flushwin_valid", valid, 5'b10001);

    // STOP: one advance then frozen.
    clear_mem();
    mem[0] = STOP; bt = 1'b0;
    do_reset();
    cycles(26);
    chk("stop_halted", halted, 1);
    chk("stop_valid", valid, 5'b11111);
    do_reset();
    cycles(2);

    // Random programs with periodic resets.
    for (int i = 0; i < 64; i++) begin
      r = 8'($urandom);
      if (r[3:0] == 4'd1) r[3:0] = 4'hA;
      mem[i] = r;
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bt  = 1'($urandom);
      tgt = int'($urandom_range(0, 63));
      if (i % 150 == 149) do_reset();
      cycle();
    end
    chk("rand_small_sat", s_cnt, (m_cnt > 3) ? 3 : m_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
